// File: rtl/co_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout and ALU op codes.
package co_pkg;

    localparam int unsigned CTRL_W = 14;

    // Bit positions inside the 14-bit control bundle (MSB first)
    localparam int unsigned BRANCH_BIT        = 13;
    localparam int unsigned MEM_TO_REG_HI     = 12;
    localparam int unsigned MEM_TO_REG_LO     = 11;
    localparam int unsigned BRANCH_TYPE_HI    = 10;
    localparam int unsigned BRANCH_TYPE_LO    = 9;
    localparam int unsigned MEM_READ_BIT      = 8;
    localparam int unsigned MEM_WRITE_BIT     = 7;
    localparam int unsigned ALU_OP_HI         = 6;
    localparam int unsigned ALU_OP_LO         = 4;
    localparam int unsigned ALU_SRC_BIT       = 3;
    localparam int unsigned REG_WRITE_BIT     = 2;
    localparam int unsigned REG_DST_HI        = 1;
    localparam int unsigned REG_DST_LO        = 0;

    localparam int unsigned BUBBLE_CNT_W      = 16;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluSlt = 3'd4,
        AluXor = 3'd5,
        AluNor = 3'd6,
        AluSll = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic       branch;
        logic [1:0] mem_to_reg;
        logic [1:0] branch_type;
        logic       mem_read;
        logic       mem_write;
        alu_op_e    alu_op;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] reg_dst;
    } ctrl_t;

    // Saturating increment; holds at all-ones instead of wrapping
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
        return (v == {BUBBLE_CNT_W{1'b1}}) ? v : v + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX holds a load whose destination the ID instruction reads.
module hazard_detect
    import co_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    // $0 is hard-wired, so a load targeting it never creates a dependency
    always_comb begin
        rs_match = (ex_rt_i == id_rs_i);
        rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);
        hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != 5'd0) & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
    import co_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic [31:0]             pc_plus4_i,
    input  logic [31:0]             rs_data_i,
    input  logic [31:0]             rt_data_i,
    input  logic [31:0]             imm_ext_i,
    input  logic [4:0]              rs_i,
    input  logic [4:0]              rt_i,
    input  logic [4:0]              rd_i,
    input  logic                    uses_rt_i,
    input  logic                    flush_i,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic [31:0]             pc_plus4_o,
    output logic [31:0]             rs_data_o,
    output logic [31:0]             rt_data_o,
    output logic [31:0]             imm_ext_o,
    output logic [4:0]              rs_o,
    output logic [4:0]              rt_o,
    output logic [4:0]              rd_o,
    output logic                    valid_o,
    output logic                    stall_o,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

    logic [CTRL_W-1:0]       ctrl_d,       ctrl_q;
    logic [31:0]             pc_plus4_d,   pc_plus4_q;
    logic [31:0]             rs_data_d,    rs_data_q;
    logic [31:0]             rt_data_d,    rt_data_q;
    logic [31:0]             imm_ext_d,    imm_ext_q;
    logic [4:0]              rs_d,         rs_q;
    logic [4:0]              rt_d,         rt_q;
    logic [4:0]              rd_d,         rd_q;
    logic                    valid_d,      valid_q;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    logic hazard;

    hazard_detect u_hazard_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q[MEM_READ_BIT]),
        .ex_rt_i       (rt_q),
        .id_rs_i       (rs_i),
        .id_rt_i       (rt_i),
        .id_uses_rt_i  (uses_rt_i),
        .hazard_o      (hazard)
    );

    // Flush outranks the hazard: the killed instruction must not freeze the front end
    always_comb begin
        stall_o = hazard & ~flush_i;
    end

    // Next-state: data always follows ID; only ctrl/valid/counter depend on flush and stall
    always_comb begin
        pc_plus4_d   = pc_plus4_i;
        rs_data_d    = rs_data_i;
        rt_data_d    = rt_data_i;
        imm_ext_d    = imm_ext_i;
        rs_d         = rs_i;
        rt_d         = rt_i;
        rd_d         = rd_i;
        ctrl_d       = ctrl_i;
        valid_d      = 1'b1;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_i) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (hazard) begin
            // Zero ctrl means no RegWrite/MemWrite/MemRead/Branch reaches EX
            ctrl_d       = '0;
            valid_d      = 1'b0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
    end

    // Pipeline registers and bubble counter, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q       <= '0;
            pc_plus4_q   <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_ext_q    <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            pc_plus4_q   <= pc_plus4_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_ext_q    <= imm_ext_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Output wiring
    always_comb begin
        ctrl_o       = ctrl_q;
        pc_plus4_o   = pc_plus4_q;
        rs_data_o    = rs_data_q;
        rt_data_o    = rt_data_q;
        imm_ext_o    = imm_ext_q;
        rs_o         = rs_q;
        rt_o         = rt_q;
        rd_o         = rd_q;
        valid_o      = valid_q;
        bubble_cnt_o = bubble_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, randomized model run, saturation/reset.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [13:0] ctrl_i;
    logic [31:0] pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic        uses_rt_i, flush_i;
    logic [13:0] ctrl_o;
    logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        valid_o, stall_o;
    logic [15:0] bubble_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [13:0] LW   = 14'h010C; // MemRead | ALUSrc | RegWrite
    localparam logic [13:0] ADDR = 14'h0004; // RegWrite only
    localparam logic [13:0] ADDI = 14'h0B0C;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ctrl_i       (ctrl_i),
        .pc_plus4_i   (pc_plus4_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .imm_ext_i    (imm_ext_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .uses_rt_i    (uses_rt_i),
        .flush_i      (flush_i),
        .ctrl_o       (ctrl_o),
        .pc_plus4_o   (pc_plus4_o),
        .rs_data_o    (rs_data_o),
        .rt_data_o    (rt_data_o),
        .imm_ext_o    (imm_ext_o),
        .rs_o         (rs_o),
        .rt_o         (rt_o),
        .rd_o         (rd_o),
        .valid_o      (valid_o),
        .stall_o      (stall_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_id(input logic [13:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic fl, input logic [31:0] rsd);
        ctrl_i     = c;
        rs_i       = rs;
        rt_i       = rt;
        uses_rt_i  = ur;
        flush_i    = fl;
        rs_data_i  = rsd;
    endtask

    task automatic edge_step();
        @(posedge clk_i);
        #1;
    endtask

    // Directed vector: ID inputs, expected stall this cycle, expected EX state after the edge
    typedef struct {
        logic [13:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        flush;
        logic [31:0] rsd;
        logic        exp_stall;
        logic [13:0] exp_ctrl;
        logic        exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[14];

    // Reference model of the EX slot, derived from the stage rules
    typedef struct {
        logic [13:0] ctrl;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic        valid;
        int          cnt;
    } ex_t;

    ex_t m;

    function automatic logic model_hazard();
        if (!m.valid || !m.ctrl[8] || m.rt == 5'd0) return 1'b0;
        return (m.rt == rs_i) || (uses_rt_i && (m.rt == rt_i));
    endfunction

    task automatic model_clear();
        m.ctrl = '0; m.pc = '0; m.rsd = '0; m.rtd = '0; m.imm = '0;
        m.rs = '0; m.rt = '0; m.rd = '0; m.valid = 1'b0; m.cnt = 0;
    endtask

    initial begin
        rst_i      = 1'b1;
        pc_plus4_i = '0;
        rt_data_i  = '0;
        imm_ext_i  = '0;
        rd_i       = '0;
        set_id(14'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);

        // Reset state
        edge_step();
        edge_step();
        chk("reset_ctrl", 32'(ctrl_o), 32'h0);
        chk("reset_valid", 32'(valid_o), 32'h0);
        chk("reset_cnt", 32'(bubble_cnt_o), 32'h0);
        chk("reset_rs_data", rs_data_o, 32'h0);
        chk("reset_stall", 32'(stall_o), 32'h0);
        rst_i = 1'b0;

        //           ctrl  rs  rt  ur fl rsd    stall ctrl  v  cnt
        vecs[0]  = '{ADDI, 1,  0,  0, 0, 32'h5, 0,    ADDI, 1, 0};
        vecs[1]  = '{LW,   2,  8,  0, 0, 32'h6, 0,    LW,   1, 0};
        vecs[2]  = '{ADDR, 8,  3,  0, 0, 32'h7, 1,    0,    0, 1};
        vecs[3]  = '{ADDR, 8,  3,  0, 0, 32'h7, 0,    ADDR, 1, 1};
        vecs[4]  = '{LW,   0,  8,  0, 0, 32'h8, 0,    LW,   1, 1};
        vecs[5]  = '{ADDR, 1,  8,  0, 0, 32'h9, 0,    ADDR, 1, 1};
        vecs[6]  = '{LW,   0,  8,  0, 0, 32'hA, 0,    LW,   1, 1};
        vecs[7]  = '{ADDR, 1,  8,  1, 0, 32'hB, 1,    0,    0, 2};
        vecs[8]  = '{ADDR, 1,  2,  1, 0, 32'hC, 0,    ADDR, 1, 2};
        vecs[9]  = '{LW,   0,  0,  0, 0, 32'hD, 0,    LW,   1, 2};
        vecs[10] = '{ADDR, 0,  0,  1, 0, 32'hE, 0,    ADDR, 1, 2};
        vecs[11] = '{LW,   0,  8,  0, 0, 32'hF, 0,    LW,   1, 2};
        vecs[12] = '{ADDR, 8,  1,  0, 1, 32'h10, 0,   0,    0, 2};
        vecs[13] = '{ADDI, 1,  0,  0, 0, 32'h11, 0,   ADDI, 1, 2};

        for (int i = 0; i < 14; i++) begin
            set_id(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].flush,
                   vecs[i].rsd);
            @(negedge clk_i);
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
            edge_step();
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_o), 32'(vecs[i].exp_ctrl));
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_cnt", i), 32'(bubble_cnt_o), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_rs_data", i), rs_data_o, vecs[i].rsd);
        end

        // Randomized run against the model
        rst_i = 1'b1;
        edge_step();
        rst_i = 1'b0;
        model_clear();
        for (int i = 0; i < 3000; i++) begin
            logic hz;
            rst_i      = ($urandom_range(0, 59) == 0);
            flush_i    = ($urandom_range(0, 7) == 0);
            ctrl_i     = 14'($urandom);
            if ($urandom_range(0, 1) == 1) ctrl_i[8] = 1'b1;
            pc_plus4_i = $urandom;
            rs_data_i  = $urandom;
            rt_data_i  = $urandom;
            imm_ext_i  = $urandom;
            rs_i       = 5'($urandom_range(0, 3));
            rt_i       = 5'($urandom_range(0, 3));
            rd_i       = 5'($urandom);
            uses_rt_i  = 1'($urandom);
            @(negedge clk_i);
            hz = model_hazard();
            chk("rnd_stall", 32'(stall_o), 32'(hz & ~flush_i));
            edge_step();
            if (rst_i) begin
                model_clear();
            end else begin
                m.pc = pc_plus4_i; m.rsd = rs_data_i; m.rtd = rt_data_i; m.imm = imm_ext_i;
                m.rs = rs_i; m.rt = rt_i; m.rd = rd_i;
                if (flush_i) begin
                    m.ctrl = '0; m.valid = 1'b0;
                end else if (hz) begin
                    m.ctrl = '0; m.valid = 1'b0;
                    if (m.cnt < 65535) m.cnt = m.cnt + 1;
                end else begin
                    m.ctrl = ctrl_i; m.valid = 1'b1;
                end
            end
            chk("rnd_ctrl", 32'(ctrl_o), 32'(m.ctrl));
            chk("rnd_valid", 32'(valid_o), 32'(m.valid));
            chk("rnd_cnt", 32'(bubble_cnt_o), 32'(m.cnt));
            chk("rnd_pc", pc_plus4_o, m.pc);
            chk("rnd_rs_data", rs_data_o, m.rsd);
            chk("rnd_rt_data", rt_data_o, m.rtd);
            chk("rnd_imm", imm_ext_o, m.imm);
            chk("rnd_regs", {17'h0, rs_o, rt_o, rd_o}, {17'h0, m.rs, m.rt, m.rd});
        end

        // Saturation: 65535 load-use bubbles, two cycles each
        rst_i = 1'b1;
        flush_i = 1'b0;
        edge_step();
        rst_i = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            set_id(LW, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0);
            edge_step();
            set_id(ADDR, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0);
            edge_step();
        end
        chk("sat_preload", 32'(bubble_cnt_o), 32'hFFFF);
        set_id(LW, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0);
        edge_step();
        set_id(ADDR, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("sat_stall", 32'(stall_o), 32'h1);
        edge_step();
        chk("sat_hold", 32'(bubble_cnt_o), 32'hFFFF);
        chk("sat_valid", 32'(valid_o), 32'h0);

        // Reset during a stall cycle discards it; ID is recaptured afterwards
        set_id(LW, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0);
        edge_step();
        set_id(ADDR, 5'd5, 5'd0, 1'b0, 1'b0, 32'h77);
        @(negedge clk_i);
        chk("midstall_stall", 32'(stall_o), 32'h1);
        rst_i = 1'b1;
        edge_step();
        chk("midstall_ctrl", 32'(ctrl_o), 32'h0);
        chk("midstall_valid", 32'(valid_o), 32'h0);
        chk("midstall_cnt", 32'(bubble_cnt_o), 32'h0);
        chk("midstall_rs_data", rs_data_o, 32'h0);
        chk("midstall_rt", 32'(rt_o), 32'h0);
        chk("midstall_stall_after", 32'(stall_o), 32'h0);
        rst_i = 1'b0;
        edge_step();
        chk("recapture_ctrl", 32'(ctrl_o), 32'(ADDR));
        chk("recapture_valid", 32'(valid_o), 32'h1);
        chk("recapture_rs_data", rs_data_o, 32'h77);
        chk("recapture_cnt", 32'(bubble_cnt_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
